// File: rtl/vector_ram_slave.sv
// vector_ram_slave: responder end of the vector RAM interface.
// A PARALLELISM-lane register-file RAM with a W/B write channel that acknowledges each
// beat with a running beat count, and an AR/R read channel with one registered output
// stage. The two channels are fully independent.
module vector_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PARALLELISM = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    // write channel
    input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] waddr,
    input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata,
    input  logic                                    wvalid,
    output logic                                    wready,
    // write acknowledge channel
    output logic [DATA_WIDTH-1:0]                   bdata,
    output logic                                    bvalid,
    input  logic                                    bready,
    // read request channel
    input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] raddr,
    input  logic                                    arvalid,
    output logic                                    arready,
    // read data channel
    output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata,
    output logic                                    rvalid,
    input  logic                                    rready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]                   mem [DEPTH];
    logic [DATA_WIDTH-1:0]                   count_q;
    logic [DATA_WIDTH-1:0]                   bdata_q;
    logic                                    bvalid_q;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata_q;
    logic                                    rvalid_q;
    logic                                    w_fire;
    logic                                    ar_fire;

    // Ready whenever the output slot is empty or being drained this cycle; low in reset.
    always_comb begin
        wready  = rst_n && (!bvalid_q || bready);
        arready = rst_n && (!rvalid_q || rready);
        w_fire  = wvalid && wready;
        ar_fire = arvalid && arready;
    end

    // Storage array; lanes are written in ascending order so the highest lane wins a
    // collision (last nonblocking assignment to the same word takes effect).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (w_fire) begin
            for (int i = 0; i < PARALLELISM; i++) begin
                mem[waddr[i]] <= wdata[i];
            end
        end
    end

    // Write acknowledge: one B beat per W beat, payload is the post-increment beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            bdata_q  <= '0;
            bvalid_q <= 1'b0;
        end else if (w_fire) begin
            count_q  <= count_q + 1'b1;
            bdata_q  <= count_q + 1'b1;
            bvalid_q <= 1'b1;
        end else if (bvalid_q && bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read data stage; mem is sampled before any same-edge write lands (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (ar_fire) begin
            for (int i = 0; i < PARALLELISM; i++) begin
                rdata_q[i] <= mem[raddr[i]];
            end
            rvalid_q <= 1'b1;
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bdata  = bdata_q;
    assign bvalid = bvalid_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_vector_ram_slave.sv
// Directed self-checking bench for vector_ram_slave (default parameters).
module tb_vector_ram_slave;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned P  = 3;

    logic                   clk;
    logic                   rst_n;
    logic [P-1:0][AW-1:0]   waddr;
    logic [P-1:0][DW-1:0]   wdata;
    logic                   wvalid;
    logic                   wready;
    logic [DW-1:0]          bdata;
    logic                   bvalid;
    logic                   bready;
    logic [P-1:0][AW-1:0]   raddr;
    logic                   arvalid;
    logic                   arready;
    logic [P-1:0][DW-1:0]   rdata;
    logic                   rvalid;
    logic                   rready;

    int checks   = 0;
    int failures = 0;

    vector_ram_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .PARALLELISM (P)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waddr   (waddr),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .bdata   (bdata),
        .bvalid  (bvalid),
        .bready  (bready),
        .raddr   (raddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        waddr[0] = a0; waddr[1] = a1; waddr[2] = a2;
        wdata[0] = d0; wdata[1] = d1; wdata[2] = d2;
    endtask

    task automatic set_r(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
        raddr[0] = a0; raddr[1] = a1; raddr[2] = a2;
    endtask

    initial begin
        rst_n   = 1'b0;
        waddr   = '0;
        wdata   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        raddr   = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        tick();
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;

        // 1: idle after reset, read zeros
        check("idle_wready", {31'b0, wready}, 32'd1);
        check("idle_arready", {31'b0, arready}, 32'd1);
        check("idle_bvalid", {31'b0, bvalid}, 32'd0);
        check("idle_rvalid", {31'b0, rvalid}, 32'd0);
        check("idle_bdata", bdata, 32'd0);
        set_r(0, 1, 2);
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t1_rvalid", {31'b0, rvalid}, 32'd1);
        check("t1_rdata0", rdata[0], 32'd0);
        check("t1_rdata2", rdata[2], 32'd0);

        // 2: basic write then reversed read
        set_w(3, 4, 5, 32'hA, 32'hB, 32'hC);
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_bvalid", {31'b0, bvalid}, 32'd1);
        check("t2_bdata", bdata, 32'd1);
        check("t2_rvalid_drop", {31'b0, rvalid}, 32'd0);
        set_r(5, 4, 3);
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t2_bvalid_drop", {31'b0, bvalid}, 32'd0);
        check("t2_bdata_hold", bdata, 32'd1);
        check("t2_rdata0", rdata[0], 32'hC);
        check("t2_rdata1", rdata[1], 32'hB);
        check("t2_rdata2", rdata[2], 32'hA);

        // 3: lane collision, highest lane wins
        set_w(7, 7, 7, 32'd1, 32'd2, 32'd3);
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t3_bdata", bdata, 32'd2);
        set_r(7, 0, 0);
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t3_rdata0", rdata[0], 32'd3);

        // 4: B backpressure
        bready = 1'b0;
        set_w(10, 11, 12, 32'h10, 32'h11, 32'h12);
        wvalid = 1'b1;
        tick();
        check("t4_bvalid", {31'b0, bvalid}, 32'd1);
        check("t4_bdata", bdata, 32'd3);
        check("t4_wready_low", {31'b0, wready}, 32'd0);
        set_w(13, 14, 15, 32'h20, 32'h21, 32'h22);
        tick();
        check("t4_bdata_stable", bdata, 32'd3);
        check("t4_bvalid_hold", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        #1;
        check("t4_wready_back", {31'b0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        check("t4_bdata2", bdata, 32'd4);
        check("t4_bvalid2", {31'b0, bvalid}, 32'd1);
        tick();
        check("t4_bvalid_drop", {31'b0, bvalid}, 32'd0);
        check("t4_bdata_once", bdata, 32'd4);

        // 4b: R backpressure
        rready = 1'b0;
        set_r(10, 11, 13);
        arvalid = 1'b1;
        tick();
        set_r(12, 14, 15);
        check("t4_rvalid", {31'b0, rvalid}, 32'd1);
        check("t4_rdata0", rdata[0], 32'h10);
        check("t4_rdata1", rdata[1], 32'h11);
        check("t4_rdata2", rdata[2], 32'h20);
        check("t4_arready_low", {31'b0, arready}, 32'd0);
        tick();
        check("t4_rdata_stable", rdata[2], 32'h20);
        check("t4_rvalid_hold", {31'b0, rvalid}, 32'd1);
        rready = 1'b1;
        #1;
        check("t4_arready_back", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        check("t4_rdata_next0", rdata[0], 32'h12);
        check("t4_rdata_next2", rdata[2], 32'h22);
        tick();
        check("t4_rvalid_drop", {31'b0, rvalid}, 32'd0);

        // 5: same-edge write and read is read-first
        set_w(9, 9, 9, 32'h1, 32'h1, 32'h1);
        wvalid = 1'b1;
        tick();
        check("t5_bdata_pre", bdata, 32'd5);
        set_w(9, 20, 21, 32'hDEAD, 32'h5, 32'h6);
        set_r(9, 9, 9);
        arvalid = 1'b1;
        tick();
        wvalid  = 1'b0;
        check("t5_rdata_old", rdata[0], 32'h1);
        check("t5_bdata", bdata, 32'd6);
        tick();
        arvalid = 1'b0;
        check("t5_rdata_new", rdata[0], 32'hDEAD);

        // 6: asynchronous reset with both channels pending
        bready = 1'b0;
        rready = 1'b0;
        set_w(1, 2, 3, 32'h77, 32'h78, 32'h79);
        wvalid  = 1'b1;
        set_r(7, 9, 10);
        arvalid = 1'b1;
        tick();
        wvalid  = 1'b0;
        arvalid = 1'b0;
        check("t6_bvalid_pre", {31'b0, bvalid}, 32'd1);
        check("t6_bdata_pre", bdata, 32'd7);
        check("t6_rvalid_pre", {31'b0, rvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_bvalid_async", {31'b0, bvalid}, 32'd0);
        check("t6_rvalid_async", {31'b0, rvalid}, 32'd0);
        check("t6_bdata_async", bdata, 32'd0);
        check("t6_rdata_async", rdata[0], 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        bready = 1'b1;
        rready = 1'b1;
        #1;
        set_r(3, 9, 7);
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t6_rdata0", rdata[0], 32'd0);
        check("t6_rdata1", rdata[1], 32'd0);
        check("t6_rdata2", rdata[2], 32'd0);
        set_w(0, 1, 2, 32'h5, 32'h6, 32'h7);
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t6_bdata_restart", bdata, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
